// File: rtl/infer_sequencer.sv
// infer_sequencer: host-side sequencer for one inference pass of the conv/pool/FC core.
// Streams weight bytes (when not resident) and then image bytes into the core RAMs,
// waits for the core result with a timeout, and returns the result byte to the host.
module infer_sequencer #(
   parameter int unsigned W_BYTES = 54,
   parameter int unsigned D_BYTES = 64,
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_start,
   input  logic       cmd_reload_w,
   input  logic       cmd_abort,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   output logic       s_ready,
   output logic       core_mode,
   output logic       core_ram_en,
   output logic [7:0] core_din,
   output logic       core_clr,
   input  logic       core_done,
   input  logic [7:0] core_dout,
   output logic       res_valid,
   output logic [7:0] res_data,
   input  logic       res_ready,
   output logic       busy,
   output logic       w_loaded,
   output logic       err_timeout
);

   // Timer only has to count the WAIT cycles 0..TIMEOUT-1.
   localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [CNT_W-1:0] W_LAST = CNT_W'(W_BYTES - 1);
   localparam logic [CNT_W-1:0] D_LAST = CNT_W'(D_BYTES - 1);
   localparam logic [TMR_W-1:0] T_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_W,
      ST_LOAD_D,
      ST_WAIT,
      ST_RESULT
   } state_t;

   state_t             state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [TMR_W-1:0]   timer_q,     timer_d;
   logic               w_loaded_q,  w_loaded_d;
   logic               err_q,       err_d;
   logic               res_valid_q, res_valid_d;
   logic [7:0]         res_data_q,  res_data_d;
   logic               clr_q,       clr_d;
   logic               mode_q,      mode_d;
   logic               xfer_ready;
   logic               accept;

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         timer_q     <= '0;
         w_loaded_q  <= 1'b0;
         err_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= 8'h00;
         clr_q       <= 1'b0;
         mode_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         timer_q     <= timer_d;
         w_loaded_q  <= w_loaded_d;
         err_q       <= err_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         clr_q       <= clr_d;
         mode_q      <= mode_d;
      end
   end

   // Next-state logic; abort outranks everything outside IDLE and blocks byte acceptance.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      timer_d     = timer_q;
      w_loaded_d  = w_loaded_q;
      err_d       = err_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      clr_d       = 1'b0;
      xfer_ready  = 1'b0;
      accept      = 1'b0;

      if ((state_q != ST_IDLE) && cmd_abort) begin
         state_d     = ST_IDLE;
         clr_d       = 1'b1;
         res_valid_d = 1'b0;
         cnt_d       = '0;
         timer_d     = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_start && !cmd_abort) begin
                  clr_d = 1'b1;
                  err_d = 1'b0;
                  cnt_d = '0;
                  if (cmd_reload_w || !w_loaded_q) begin
                     state_d    = ST_LOAD_W;
                     w_loaded_d = 1'b0;
                  end else begin
                     state_d = ST_LOAD_D;
                  end
               end
            end

            ST_LOAD_W: begin
               xfer_ready = 1'b1;
               accept     = s_valid;
               if (accept) begin
                  if (cnt_q == W_LAST) begin
                     cnt_d      = '0;
                     w_loaded_d = 1'b1;
                     state_d    = ST_LOAD_D;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end

            ST_LOAD_D: begin
               xfer_ready = 1'b1;
               accept     = s_valid;
               if (accept) begin
                  if (cnt_q == D_LAST) begin
                     cnt_d   = '0;
                     timer_d = '0;
                     state_d = ST_WAIT;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end

            ST_WAIT: begin
               if (core_done) begin
                  res_data_d  = core_dout;
                  res_valid_d = 1'b1;
                  timer_d     = '0;
                  state_d     = ST_RESULT;
               end else if (timer_q == T_LAST) begin
                  err_d   = 1'b1;
                  timer_d = '0;
                  state_d = ST_IDLE;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end

            ST_RESULT: begin
               if (res_ready) begin
                  res_valid_d = 1'b0;
                  state_d     = ST_IDLE;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      mode_d = (state_d == ST_LOAD_W);
   end

   // Byte path to the core RAMs is combinational so the strobe lines up with s_data.
   assign s_ready     = xfer_ready;
   assign core_ram_en = accept;
   assign core_din    = s_data;

   assign core_mode   = mode_q;
   assign core_clr    = clr_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign w_loaded    = w_loaded_q;
   assign err_timeout = err_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_infer_sequencer.sv
// Bench for infer_sequencer: driver pushes expected strobes/results into queues,
// independent monitors pop and compare whenever the DUT presents a strobe or a result.
module tb_infer_sequencer;

   localparam int unsigned W_BYTES = 54;
   localparam int unsigned D_BYTES = 64;
   localparam int unsigned TIMEOUT = 15;
   localparam int unsigned CNT_W   = 7;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_start, cmd_reload_w, cmd_abort;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       core_mode, core_ram_en, core_clr;
   logic [7:0] core_din;
   logic       core_done;
   logic [7:0] core_dout;
   logic       res_valid;
   logic [7:0] res_data;
   logic       res_ready;
   logic       busy, w_loaded, err_timeout;

   always #5 clk = ~clk;

   infer_sequencer #(
      .W_BYTES(W_BYTES), .D_BYTES(D_BYTES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_start(cmd_start), .cmd_reload_w(cmd_reload_w), .cmd_abort(cmd_abort),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .core_mode(core_mode), .core_ram_en(core_ram_en), .core_din(core_din),
      .core_clr(core_clr), .core_done(core_done), .core_dout(core_dout),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .busy(busy), .w_loaded(w_loaded), .err_timeout(err_timeout)
   );

   typedef struct packed {
      logic       mode;
      logic [7:0] data;
   } strobe_t;

   strobe_t    exp_strobe[$];
   logic [7:0] exp_res[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_w_strobes = 0;
   int         n_d_strobes = 0;

   // Reference model of the host-visible status
   bit w_loaded_m = 1'b0;
   bit err_m      = 1'b0;
   bit noise      = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobe monitor: every write strobe must match the oldest expected byte
   always @(negedge clk) begin : mon_strobe
      strobe_t e;
      if (rst_n === 1'b1 && core_ram_en === 1'b1) begin
         if (core_mode === 1'b1) n_w_strobes++;
         else n_d_strobes++;
         if (exp_strobe.size() == 0) begin
            check("unexpected_strobe", 32'(core_din), 32'hFFFF_FFFF);
         end else begin
            e = exp_strobe.pop_front();
            check("strobe_mode", 32'(core_mode), 32'(e.mode));
            check("strobe_din", 32'(core_din), 32'(e.data));
         end
      end
   end

   // Result monitor: compares on each completed result handshake
   always @(negedge clk) begin : mon_result
      logic [7:0] e;
      if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
         if (exp_res.size() == 0) begin
            check("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
         end else begin
            e = exp_res.pop_front();
            check("res_data", 32'(res_data), 32'(e));
         end
      end
   end

   // Offer one byte until accepted; optional noise on core_done/cmd_start must be ignored
   task automatic send_byte(input logic [7:0] b, input logic mode);
      strobe_t e;
      bit      acc;
      int      g;
      e.mode = mode;
      e.data = b;
      exp_strobe.push_back(e);
      s_valid = 1'b1;
      s_data  = b;
      if (noise) begin
         core_done = ($urandom_range(0, 3) == 0);
         cmd_start = ($urandom_range(0, 7) == 0);
      end
      acc = 1'b0;
      g   = 0;
      while (!acc && g < 64) begin
         @(negedge clk);
         acc = s_ready;
         tick();
         g++;
      end
      if (!acc) check("byte_accept", 0, 1);
      s_valid   = 1'b0;
      core_done = 1'b0;
      cmd_start = 1'b0;
   endtask

   // gap_kind: 0 back-to-back, 1 idle cycle between bytes, 2 random idle cycles
   task automatic send_stream(input int n, input logic mode, input logic [7:0] base,
                              input bit pat, input int gap_kind);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = pat ? 8'(base + 8'(i)) : 8'($urandom);
         if (gap_kind == 1 && i > 0) begin
            @(negedge clk);
            if (i == n - 1) begin
               check("ready_before_last", 32'(s_ready), 1);
               check("busy_before_last", 32'(busy), 1);
            end
            tick();
         end else if (gap_kind == 2 && $urandom_range(0, 3) == 0) begin
            tick();
         end
         send_byte(b, mode);
      end
   endtask

   task automatic do_start(input bit reload, input bit exp_w);
      cmd_start    = 1'b1;
      cmd_reload_w = reload;
      @(negedge clk);
      check("s_ready_idle", 32'(s_ready), 0);
      check("err_before_start", 32'(err_timeout), 32'(err_m));
      tick();
      cmd_start    = 1'b0;
      cmd_reload_w = 1'b0;
      err_m        = 1'b0;
      if (exp_w) w_loaded_m = 1'b0;
      @(negedge clk);
      check("clr_pulse", 32'(core_clr), 1);
      check("busy_start", 32'(busy), 1);
      check("mode_start", 32'(core_mode), 32'(exp_w));
      check("err_cleared", 32'(err_timeout), 0);
      check("w_loaded_start", 32'(w_loaded), 32'(w_loaded_m));
      tick();
   endtask

   // ending: 0 result handshake, 1 timeout, 2 abort in WAIT
   task automatic run_pass(input bit reload, input bit pat, input int gap_kind, input int ending,
                           input int dly, input int hold, input bit extra_done, input bit nz);
      bit         exp_w;
      bit         seen;
      logic [7:0] dout;
      int         n, w0, d0;
      exp_w = reload || !w_loaded_m;
      w0 = n_w_strobes;
      d0 = n_d_strobes;
      do_start(reload, exp_w);
      noise = nz;
      if (exp_w) begin
         send_stream(W_BYTES, 1'b1, 8'h01, pat, 0);
         w_loaded_m = 1'b1;
      end
      send_stream(D_BYTES, 1'b0, 8'h40, pat, gap_kind);
      noise = 1'b0;
      // first WAIT cycle
      @(negedge clk);
      check("wait_s_ready", 32'(s_ready), 0);
      check("wait_busy", 32'(busy), 1);
      check("wait_w_loaded", 32'(w_loaded), 32'(w_loaded_m));
      check("w_strobes", n_w_strobes - w0, exp_w ? W_BYTES : 0);
      check("d_strobes", n_d_strobes - d0, D_BYTES);
      tick();
      if (ending == 0) begin
         repeat (dly - 1) tick();
         dout = pat ? 8'h5A : 8'($urandom);
         core_done = 1'b1;
         core_dout = dout;
         exp_res.push_back(dout);
         @(negedge clk);
         check("res_valid_pre", 32'(res_valid), 0);
         tick();
         core_done = 1'b0;
         @(negedge clk);
         check("res_valid_lat", 32'(res_valid), 1);
         tick();
         for (int k = 0; k < hold; k++) begin
            if (extra_done && k == hold / 2) begin
               core_done = 1'b1;
               core_dout = ~dout;
            end
            tick();
            core_done = 1'b0;
         end
         res_ready = 1'b1;
         @(negedge clk);
         check("res_valid_hs", 32'(res_valid), 1);
         check("busy_hs", 32'(busy), 1);
         tick();
         res_ready = 1'b0;
         @(negedge clk);
         check("res_valid_drop", 32'(res_valid), 0);
         check("busy_drop", 32'(busy), 0);
         tick();
      end else if (ending == 1) begin
         seen = 1'b0;
         n    = 1;
         while (!seen && n < 40) begin
            @(negedge clk);
            if (err_timeout === 1'b1) seen = 1'b1;
            else begin
               tick();
               n++;
            end
         end
         err_m = 1'b1;
         check("timeout_seen", 32'(seen), 1);
         check("timeout_cycles", n, TIMEOUT);
         check("timeout_idle", 32'(busy), 0);
         check("timeout_res_valid", 32'(res_valid), 0);
         check("timeout_w_loaded", 32'(w_loaded), 32'(w_loaded_m));
         tick();
      end else begin
         cmd_abort = 1'b1;
         @(negedge clk);
         check("abort_wait_ready", 32'(s_ready), 0);
         tick();
         cmd_abort = 1'b0;
         @(negedge clk);
         check("abort_wait_idle", 32'(busy), 0);
         check("abort_wait_w_loaded", 32'(w_loaded), 32'(w_loaded_m));
         check("abort_wait_clr", 32'(core_clr), 1);
         tick();
      end
   endtask

   // Abort a weight load after n_bytes bytes
   task automatic abort_in_load_w(input int n_bytes);
      do_start(1'b1, 1'b1);
      send_stream(n_bytes, 1'b1, 8'h01, 1'b1, 0);
      cmd_abort = 1'b1;
      s_valid   = 1'b1;
      s_data    = 8'hEE;
      @(negedge clk);
      check("abort_s_ready", 32'(s_ready), 0);
      check("abort_no_strobe", 32'(core_ram_en), 0);
      tick();
      cmd_abort = 1'b0;
      s_valid   = 1'b0;
      @(negedge clk);
      check("abort_idle", 32'(busy), 0);
      check("abort_w_loaded", 32'(w_loaded), 0);
      check("abort_clr", 32'(core_clr), 1);
      tick();
      @(negedge clk);
      check("abort_clr_one_cycle", 32'(core_clr), 0);
      check("abort_queue_drained", exp_strobe.size(), 0);
      tick();
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      rst_n        = 1'b0;
      cmd_start    = 1'b0;
      cmd_reload_w = 1'b0;
      cmd_abort    = 1'b0;
      s_valid      = 1'b0;
      s_data       = 8'h00;
      core_done    = 1'b0;
      core_dout    = 8'h00;
      res_ready    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_w_loaded", 32'(w_loaded), 0);
      check("rst_err", 32'(err_timeout), 0);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_res_data", 32'(res_data), 0);
      check("rst_clr", 32'(core_clr), 0);
      check("rst_mode", 32'(core_mode), 0);
      check("rst_s_ready", 32'(s_ready), 0);
      check("rst_ram_en", 32'(core_ram_en), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Cold start: weights and data, result 0x5A five cycles after the last byte
      run_pass(1'b0, 1'b1, 0, 0, 5, 0, 1'b0, 1'b0);
      // Weights resident: data only
      run_pass(1'b0, 1'b0, 0, 0, 3, 2, 1'b0, 1'b0);
      // s_valid toggling during the data phase
      run_pass(1'b0, 1'b0, 1, 0, 1, 0, 1'b0, 1'b0);
      // No core_done: timeout
      run_pass(1'b0, 1'b0, 0, 1, 0, 0, 1'b0, 1'b0);
      // Start after timeout clears the error; result held 10 cycles with a stray core_done
      run_pass(1'b0, 1'b0, 0, 0, TIMEOUT - 1, 10, 1'b1, 1'b0);
      // Abort mid-weights, then a plain start must reload every weight
      abort_in_load_w(20);
      run_pass(1'b0, 1'b0, 0, 0, 2, 0, 1'b0, 1'b0);
      // Abort in WAIT keeps weights resident
      run_pass(1'b0, 1'b0, 0, 2, 0, 0, 1'b0, 1'b0);
      // Randomised passes with ignored noise on core_done/cmd_start during loads
      for (int p = 0; p < 6; p++) begin
         run_pass(1'($urandom_range(0, 1)), 1'b0, 2,
                  ($urandom_range(0, 3) == 0) ? 1 : 0,
                  int'($urandom_range(1, TIMEOUT - 1)), int'($urandom_range(0, 4)),
                  1'($urandom_range(0, 1)), 1'b1);
      end

      check("strobe_queue_empty", exp_strobe.size(), 0);
      check("result_queue_empty", exp_res.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
